// File: rtl/spi_master_parallel.sv
// spi_master_parallel: parallel-word SPI master, CPOL=0 / CPHA=0.
// Each SCLK period carries one full NB_BITS word out on o_MOSI. The slave's
// response word on i_MISO is captured in the last LOW cycle of that period.
// SCLK is derived from i_clk; each half-phase (SETUP/HIGH/LOW) is CLK_DIV cycles.
// Optional feature: define SPI_MASTER_BURST_EN to chain words back-to-back
// without dropping o_cs when i_start is high in the last LOW cycle.
module spi_master_parallel #(
  parameter int NB_BITS = 32,
  // SCLK half-phase length in i_clk cycles. It must be at least 3 so that the
  // slave's two-flop edge detector can reload MISO before the master samples it.
  parameter int CLK_DIV = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_BITS-1:0] i_data,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_SCLK,
  output logic               o_cs,
  output logic [NB_BITS-1:0] o_MOSI,
  input  logic [NB_BITS-1:0] i_MISO
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_end;
  logic             last_low;
  logic             load_mosi;

  logic [NB_BITS-1:0] mosi_q, mosi_d;
  logic [NB_BITS-1:0] data_q, data_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  assign phase_end = (cnt_q == CNT_LAST);
  assign last_low  = (state_q == LOW) && phase_end;

  // State and phase-counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: each non-IDLE state lasts exactly CLK_DIV cycles
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    load_mosi = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_start) begin
          state_d   = SETUP;
          load_mosi = 1'b1;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_d = HIGH;
          cnt_d   = '0;
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef SPI_MASTER_BURST_EN
          // Chain the next word straight into SETUP, keeping o_cs asserted
          if (i_start) begin
            state_d   = SETUP;
            load_mosi = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    cs_d   = (state_d != IDLE);
    sclk_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    done_d = last_low;
    mosi_d = load_mosi ? i_data : mosi_q;
    data_d = last_low ? i_MISO : data_q;
  end

  // Output and data registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cs_q   <= 1'b0;
      sclk_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mosi_q <= '0;
      data_q <= '0;
    end else begin
      cs_q   <= cs_d;
      sclk_q <= sclk_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mosi_q <= mosi_d;
      data_q <= data_d;
    end
  end

  assign o_cs   = cs_q;
  assign o_SCLK = sclk_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_MOSI = mosi_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_spi_master_parallel.sv
// Bench for spi_master_parallel: two instances (CLK_DIV=4 and CLK_DIV=3), each
// attached to a behavioural parallel slave with a two-flop SCLK edge detector.
`timescale 1ns/1ps
module tb_spi_master_parallel;

  localparam int NB = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic          start   [2];
  logic [NB-1:0] dat     [2];
  logic [NB-1:0] tx      [2];
  logic [NB-1:0] odata_w [2];
  logic [NB-1:0] mosi_w  [2];
  logic [NB-1:0] miso_w  [2];
  logic          busy_w  [2];
  logic          done_w  [2];
  logic          sclk_w  [2];
  logic          cs_w    [2];

  logic          s1      [2];
  logic          s2      [2];
  logic [NB-1:0] miso_q  [2];
  logic [NB-1:0] rx_q    [2];

  int n_assert = 0;
  int n_fail   = 0;

  bit            tr_cs   [64];
  bit            tr_sclk [64];
  bit            tr_done [64];
  bit            tr_busy [64];
  logic [NB-1:0] tr_data [64];
  logic [NB-1:0] tr_rx   [64];

  always #5 clk = ~clk;

  spi_master_parallel #(.NB_BITS(NB), .CLK_DIV(4)) u_div4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start[0]),
    .i_data  (dat[0]),
    .o_data  (odata_w[0]),
    .o_busy  (busy_w[0]),
    .o_done  (done_w[0]),
    .o_SCLK  (sclk_w[0]),
    .o_cs    (cs_w[0]),
    .o_MOSI  (mosi_w[0]),
    .i_MISO  (miso_w[0])
  );

  spi_master_parallel #(.NB_BITS(NB), .CLK_DIV(3)) u_div3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start[1]),
    .i_data  (dat[1]),
    .o_data  (odata_w[1]),
    .o_busy  (busy_w[1]),
    .o_done  (done_w[1]),
    .o_SCLK  (sclk_w[1]),
    .o_cs    (cs_w[1]),
    .o_MOSI  (mosi_w[1]),
    .i_MISO  (miso_w[1])
  );

  // Slave drives its response only while selected; otherwise a decoy word
  assign miso_w[0] = cs_w[0] ? miso_q[0] : ~tx[0];
  assign miso_w[1] = cs_w[1] ? miso_q[1] : ~tx[1];

  // Behavioural slave: latch MOSI on detected SCLK rise, reload MISO on fall
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        s1[k]     <= 1'b0;
        s2[k]     <= 1'b0;
        miso_q[k] <= '0;
        rx_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        s1[k] <= sclk_w[k];
        s2[k] <= s1[k];
        if (s1[k] && !s2[k]) rx_q[k] <= mosi_w[k];
        if (!s1[k] && s2[k]) miso_q[k] <= tx[k];
      end
    end
  end

  function automatic int d_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int cnt_hi(input bit a[64], input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (a[i]) c++;
    return c;
  endfunction

  function automatic int first_hi(input bit a[64]);
    for (int i = 1; i < 64; i++) if (a[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with start[k] already set; offset o is the cycle after
  // accept edge E+o-1. mode 0: single word, 1: hold start, 2: restart in the
  // done cycle with w2/r2, 3: burst words w2 and w3 after the first.
  task automatic watch(input int k, input int n, input int mode,
                       input logic [NB-1:0] w2, input logic [NB-1:0] r2,
                       input logic [NB-1:0] w3);
    int seen = 0;
    int d3;
    d3 = 3 * d_of(k);
    for (int i = 0; i < 64; i++) begin
      tr_cs[i] = 0; tr_sclk[i] = 0; tr_done[i] = 0; tr_busy[i] = 0;
      tr_data[i] = '0; tr_rx[i] = '0;
    end
    for (int o = 1; o <= n; o++) begin
      @(negedge clk);
      tr_cs[o]   = cs_w[k];
      tr_sclk[o] = sclk_w[k];
      tr_done[o] = done_w[k];
      tr_busy[o] = busy_w[k];
      tr_data[o] = odata_w[k];
      tr_rx[o]   = rx_q[k];
      case (mode)
        0: start[k] = 1'b0;
        1: ;
        2: begin
          if (start[k]) start[k] = 1'b0;
          else if (done_w[k] && seen == 0) begin
            seen = 1;
            start[k] = 1'b1;
            dat[k] = w2;
            tx[k] = r2;
          end
        end
        default: begin
          if (o == 1) dat[k] = w2;
          if (o == d3 + 1) dat[k] = w3;
          if (o == 2 * d3 + 1) start[k] = 1'b0;
        end
      endcase
    end
  endtask

  task automatic idle_wait(input int k);
    int waited = 0;
    while (busy_w[k] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk_i("idle_reached", int'(busy_w[k]), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] w, r, w1, r1;
    int d;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; dat[k] = '0; tx[k] = '0;
    end

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk_i("rst_cs", int'(cs_w[k]), 0);
      chk_i("rst_sclk", int'(sclk_w[k]), 0);
      chk_i("rst_busy", int'(busy_w[k]), 0);
      chk_i("rst_done", int'(done_w[k]), 0);
      chk("rst_data", odata_w[k], '0);
      chk("rst_mosi", mosi_w[k], '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, CLK_DIV=4
    tx[0] = 32'hCAFE_BABE; dat[0] = 32'h1234_5678; start[0] = 1'b1;
    watch(0, 16, 0, '0, '0, '0);
    chk_i("single_cs_first", first_hi(tr_cs), 1);
    chk_i("single_cs_len", cnt_hi(tr_cs, 1, 16), 12);
    chk_i("single_busy_len", cnt_hi(tr_busy, 1, 16), 12);
    chk_i("single_sclk_first", first_hi(tr_sclk), 5);
    chk_i("single_sclk_len", cnt_hi(tr_sclk, 1, 16), 4);
    chk_i("single_done_at", first_hi(tr_done), 13);
    chk_i("single_done_cnt", cnt_hi(tr_done, 1, 16), 1);
    chk_i("single_cs_drop", int'(tr_cs[13]), 0);
    chk("single_data_before", tr_data[12], '0);
    chk("single_data", tr_data[13], 32'hCAFE_BABE);
    chk("single_slave_rx", tr_rx[13], 32'h1234_5678);
    chk("single_mosi_hold", mosi_w[0], 32'h1234_5678);

    // Asynchronous reset in the middle of HIGH
    tx[0] = $urandom; dat[0] = $urandom; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk_i("rst_mid_sclk_pre", int'(sclk_w[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_i("rst_mid_cs", int'(cs_w[0]), 0);
    chk_i("rst_mid_sclk", int'(sclk_w[0]), 0);
    chk_i("rst_mid_busy", int'(busy_w[0]), 0);
    chk_i("rst_mid_done", int'(done_w[0]), 0);
    chk("rst_mid_data", odata_w[0], '0);
    chk("rst_mid_mosi", mosi_w[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(0, 20, 0, '0, '0, '0);
    chk_i("rst_after_done", cnt_hi(tr_done, 1, 20), 0);
    chk_i("rst_after_cs", cnt_hi(tr_cs, 1, 20), 0);

`ifdef SPI_MASTER_BURST_EN
    // Burst of three words with i_start held
    tx[0] = 32'h0BAD_F00D; dat[0] = 32'd1; start[0] = 1'b1;
    watch(0, 40, 3, 32'd2, '0, 32'd3);
    chk_i("burst_cs_len", cnt_hi(tr_cs, 1, 36), 36);
    chk_i("burst_busy_len", cnt_hi(tr_busy, 1, 36), 36);
    chk_i("burst_cs_end", int'(tr_cs[37]), 0);
    chk_i("burst_done_cnt", cnt_hi(tr_done, 1, 40), 3);
    chk_i("burst_done1", int'(tr_done[13]), 1);
    chk_i("burst_done2", int'(tr_done[25]), 1);
    chk_i("burst_done3", int'(tr_done[37]), 1);
    chk("burst_rx1", tr_rx[12], 32'd1);
    chk("burst_rx2", tr_rx[24], 32'd2);
    chk("burst_rx3", tr_rx[36], 32'd3);
    chk("burst_data", tr_data[37], 32'h0BAD_F00D);
    idle_wait(0);
`else
    // i_start held through whole transfers: one word per 13 cycles
    tx[0] = $urandom; dat[0] = $urandom; start[0] = 1'b1;
    watch(0, 40, 1, '0, '0, '0);
    start[0] = 1'b0;
    chk_i("hold_done_cnt", cnt_hi(tr_done, 1, 39), 3);
    chk_i("hold_done1", int'(tr_done[13]), 1);
    chk_i("hold_done2", int'(tr_done[26]), 1);
    chk_i("hold_done3", int'(tr_done[39]), 1);
    chk_i("hold_gap1", int'(tr_cs[13]), 0);
    chk_i("hold_gap2", int'(tr_cs[26]), 0);
    chk_i("hold_cs_restart", int'(tr_cs[14]), 1);
    chk_i("hold_cs_len", cnt_hi(tr_cs, 1, 39), 36);
    idle_wait(0);
`endif

    // Back-to-back: new start in the o_done cycle
    w1 = $urandom; r1 = $urandom; r = $urandom;
    tx[0] = r1; dat[0] = w1; start[0] = 1'b1;
    watch(0, 30, 2, 32'hA5A5_A5A5, r, '0);
    chk_i("b2b_cs_before", int'(tr_cs[12]), 1);
    chk_i("b2b_cs_gap", int'(tr_cs[13]), 0);
    chk_i("b2b_cs_after", int'(tr_cs[14]), 1);
    chk_i("b2b_cs_len", cnt_hi(tr_cs, 1, 30), 24);
    chk_i("b2b_done_cnt", cnt_hi(tr_done, 1, 30), 2);
    chk_i("b2b_done2", int'(tr_done[26]), 1);
    chk("b2b_data1", tr_data[13], r1);
    chk("b2b_rx1", tr_rx[13], w1);
    chk("b2b_data2", tr_data[26], r);
    chk("b2b_rx2", tr_rx[26], 32'hA5A5_A5A5);

    // Minimum divider CLK_DIV=3
    w = $urandom;
    tx[1] = 32'hFFFF_0000; dat[1] = w; start[1] = 1'b1;
    watch(1, 12, 0, '0, '0, '0);
    chk_i("div3_cs_len", cnt_hi(tr_cs, 1, 12), 9);
    chk_i("div3_sclk_first", first_hi(tr_sclk), 4);
    chk_i("div3_sclk_len", cnt_hi(tr_sclk, 1, 12), 3);
    chk_i("div3_done_at", first_hi(tr_done), 10);
    chk("div3_data_before", tr_data[9], '0);
    chk("div3_data", tr_data[10], 32'hFFFF_0000);
    chk("div3_rx", tr_rx[10], w);

    // Randomized words against the timing/response model
    for (int i = 0; i < 8; i++) begin
      int k;
      k = i % 2;
      d = d_of(k);
      w = $urandom; r = $urandom;
      tx[k] = r; dat[k] = w; start[k] = 1'b1;
      watch(k, 3 * d + 3, 0, '0, '0, '0);
      chk_i("rand_cs_len", cnt_hi(tr_cs, 1, 3 * d + 3), 3 * d);
      chk_i("rand_done_at", first_hi(tr_done), 3 * d + 1);
      chk("rand_data", tr_data[3 * d + 1], r);
      chk("rand_rx", tr_rx[3 * d + 1], w);
      chk("rand_mosi_hold", mosi_w[k], w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
